clk_div_multi: RTL and testbench

Multi-channel programmable clock divider. It succeeds the single-channel arbitrary divider with per-channel divisor, enable and output mode, plus a shared resynchronisation input. Each channel produces a one-cycle enable tick and a registered, glitch-free divided square wave. It feeds the timing fabric: baud generators, scan/refresh strobes and sampling enables. All outputs are registers clocked by clk; no output is a combinational pass-through of clk.

---
 rtl/clk_div_multi.sv | 79 +++++++
 tb/tb_clk_div_multi.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel holds a shadow divisor (div_act) and a phase counter. It emits a
// one-cycle tick per period and a registered square wave: high for ceil(D/2)
// cycles, low for floor(D/2) cycles. A shared sync pulse realigns all enabled
// channels to phase 0. A new divisor only takes effect at a period boundary,
// on sync, or while the channel is disabled or idle.
module clk_div_multi #(
  parameter int CNT_W = 24,
  parameter int N_CH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH*CNT_W-1:0] div_fact,
  input  logic                  sync,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       active
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] d_new;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] d_thr;
    logic             wrap;
    logic             tick_r;
    logic             clk_r;
    logic             act_r;

    // Next-phase arithmetic. At a wrap the next period already runs on the
    // freshly latched divisor, so its half-period threshold is used.
    always_comb begin
      d_new   = div_fact[i*CNT_W +: CNT_W];
      wrap    = (cnt == (div_act - ONE));
      cnt_inc = wrap ? '0 : (cnt + ONE);
      d_thr   = wrap ? d_new : div_act;
    end

    // Per-channel divisor shadow, phase counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt     <= '0;
        div_act <= '0;
        tick_r  <= 1'b0;
        clk_r   <= 1'b0;
        act_r   <= 1'b0;
      end else begin
        if (!en[i] || (div_act == '0) || sync || wrap)
          div_act <= d_new;

        if (!en[i] || (div_act == '0)) begin
          cnt    <= '0;
          tick_r <= 1'b0;
          clk_r  <= 1'b0;
          act_r  <= 1'b0;
        end else if (sync) begin
          cnt    <= '0;
          tick_r <= 1'b0;
          clk_r  <= (d_new == ONE);
          act_r  <= (d_new != '0);
        end else begin
          cnt    <= cnt_inc;
          tick_r <= wrap;
          clk_r  <= (cnt_inc >= (d_thr >> 1));
          act_r  <= 1'b1;
        end
      end
    end

    assign tick[i]    = tick_r;
    assign clk_out[i] = clk_r;
    assign active[i]  = act_r;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: reference model counts position within each
// channel's current period and predicts tick/clk_out/active per cycle; a
// monitor compares the DUT against queued predictions after every edge.
module tb_clk_div_multi;

  localparam int CNT_W = 4;
  localparam int N_CH  = 4;
  localparam int VW    = 3 * N_CH;

  logic                  clk;
  logic                  rst;
  logic [N_CH-1:0]       en;
  logic [N_CH*CNT_W-1:0] div_fact;
  logic                  sync;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       active;

  int total = 0;
  int bad   = 0;
  logic [VW-1:0] exp_q[$];
  bit done = 0;

  int pos  [N_CH];
  int dcur [N_CH];

  clk_div_multi #(.CNT_W(CNT_W), .N_CH(N_CH)) dut (
    .clk(clk), .rst(rst), .en(en), .div_fact(div_fact), .sync(sync),
    .tick(tick), .clk_out(clk_out), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predict the outputs seen after the coming rising edge and queue them.
  task automatic model_and_push();
    logic [N_CH-1:0] t, c, a;
    int f;
    t = '0; c = '0; a = '0;
    for (int i = 0; i < N_CH; i++) begin
      f = int'(div_fact[i*CNT_W +: CNT_W]);
      if (rst) begin
        pos[i] = 0; dcur[i] = 0;
      end else if (!en[i]) begin
        pos[i] = 0; dcur[i] = f;
      end else if (dcur[i] == 0) begin
        pos[i] = 0; dcur[i] = f;
      end else if (sync) begin
        pos[i] = 0; dcur[i] = f;
        c[i] = (f == 1);
        a[i] = (f != 0);
      end else begin
        pos[i] = pos[i] + 1;
        if (pos[i] == dcur[i]) begin
          pos[i] = 0; t[i] = 1'b1; dcur[i] = f;
        end
        c[i] = (pos[i] >= dcur[i] / 2);
        a[i] = 1'b1;
      end
    end
    exp_q.push_back({t, c, a});
  endtask

  task automatic step(input logic r, input logic [N_CH-1:0] e,
                      input logic [N_CH*CNT_W-1:0] df, input logic s, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = r; en = e; div_fact = df; sync = s;
      model_and_push();
    end
  endtask

  function automatic logic [N_CH*CNT_W-1:0] pack(input int d3, input int d2,
                                                  input int d1, input int d0);
    pack = {d3[CNT_W-1:0], d2[CNT_W-1:0], d1[CNT_W-1:0], d0[CNT_W-1:0]};
  endfunction

  // Monitor: outputs are valid every cycle; compare one prediction per edge.
  initial begin
    logic [VW-1:0] e;
    int cyc;
    cyc = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({tick, clk_out, active} !== e) begin
          bad++;
          $display("FAIL cycle%0d outputs tick/clk_out/active: got %b/%b/%b want %b/%b/%b",
                   cyc, tick, clk_out, active, e[VW-1 -: N_CH], e[2*N_CH-1 -: N_CH], e[N_CH-1:0]);
        end
      end
    end
  end

  initial begin
    logic [N_CH*CNT_W-1:0] df;
    logic [N_CH-1:0] e;
    rst = 1'b1; en = '0; div_fact = '0; sync = 1'b0;
    for (int i = 0; i < N_CH; i++) begin pos[i] = 0; dcur[i] = 0; end

    // Reset held for three cycles, then basic divide-by-5 on channel 0.
    step(1'b1, 4'b0000, '0, 1'b0, 3);
    step(1'b0, 4'b0000, pack(0, 0, 0, 5), 1'b0, 1);
    step(1'b0, 4'b0001, pack(0, 0, 0, 5), 1'b0, 16);

    // Boundary divisors: D=1, D=2, D=0 with enable.
    step(1'b0, 4'b1111, pack(0, 2, 1, 5), 1'b0, 20);

    // Mid-period change on channel 0: 8 running, 3 loaded at cnt=2.
    step(1'b0, 4'b0000, pack(0, 0, 0, 8), 1'b0, 1);
    step(1'b0, 4'b0001, pack(0, 0, 0, 8), 1'b0, 2);
    step(1'b0, 4'b0001, pack(0, 0, 0, 3), 1'b0, 20);

    // Sync realignment of D=4 and D=6 started out of phase.
    step(1'b0, 4'b0001, pack(0, 0, 6, 4), 1'b0, 3);
    step(1'b0, 4'b0011, pack(0, 0, 6, 4), 1'b0, 4);
    step(1'b0, 4'b0011, pack(0, 0, 6, 4), 1'b1, 1);
    step(1'b0, 4'b0011, pack(0, 0, 6, 4), 1'b0, 26);

    // Drop en1 mid-period; channel 0 keeps running.
    step(1'b0, 4'b0001, pack(0, 0, 6, 4), 1'b0, 5);
    step(1'b0, 4'b0111, pack(0, 2, 6, 4), 1'b0, 7);

    // Asynchronous reset between rising edges.
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({tick, clk_out, active} !== '0) begin
      bad++;
      $display("FAIL async_reset outputs: got %b want 0", {tick, clk_out, active});
    end
    model_and_push();
    step(1'b1, 4'b0111, pack(0, 2, 6, 4), 1'b0, 2);

    // Maximum divisor for CNT_W=4.
    step(1'b0, 4'b0000, pack(0, 0, 0, 15), 1'b0, 1);
    step(1'b0, 4'b0001, pack(0, 0, 0, 15), 1'b0, 40);

    // Randomised: divisor changes, enable toggles, occasional sync.
    e = 4'b1111;
    df = pack(3, 7, 15, 1);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) e = 4'($urandom);
      if ($urandom_range(0, 7) == 0)
        df[$urandom_range(0, N_CH-1)*CNT_W +: CNT_W] = 4'($urandom_range(0, 15));
      step(1'b0, e, df, ($urandom_range(0, 40) == 0), 1);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
